// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - timed basket-counting round controller with result handshake
// Each raw input gets a 2-flop synchronizer and a stability-counter debouncer that emits a rising-edge pulse.

module game_round_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic evt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q, deb_d;
  logic          prev_q, prev_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    prev_d  = deb_q;
    cnt_d   = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_MAX) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign evt = deb_q & ~prev_q;
endmodule

module game_round_ctrl #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int ROUND_SECS      = 10,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       hoop_sw,
  output logic [7:0] time_left,
  output logic [7:0] score,
  output logic       playing,
  output logic       game_over,
  output logic       result_valid,
  output logic [7:0] result_score,
  input  logic       result_ready
);
  localparam int PW = $clog2(CLK_HZ + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [7:0]    ROUND_T   = 8'(ROUND_SECS);

  typedef enum logic [1:0] {IDLE, PLAY, REPORT, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    time_left_q, time_left_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    result_score_q, result_score_d;
  logic          playing_q, playing_d;
  logic          game_over_q, game_over_d;
  logic          result_valid_q, result_valid_d;
  logic          start_evt, hoop_evt, tick;
  logic [7:0]    score_next;

  game_round_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clock(clock), .reset(reset), .raw(start), .evt(start_evt)
  );
  game_round_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hoop_db (
    .clock(clock), .reset(reset), .raw(hoop_sw), .evt(hoop_evt)
  );

  assign tick       = (presc_q == PRESC_MAX);
  assign score_next = (hoop_evt && score_q != 8'hFF) ? score_q + 8'd1 : score_q;

  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    time_left_d    = time_left_q;
    score_d        = score_q;
    result_score_d = result_score_q;
    playing_d      = playing_q;
    game_over_d    = game_over_q;
    result_valid_d = result_valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_evt) begin
          state_d     = PLAY;
          score_d     = 8'd0;
          time_left_d = ROUND_T;
          presc_d     = '0;
          playing_d   = 1'b1;
          game_over_d = 1'b0;
        end
      end
      PLAY: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        score_d = score_next;
        if (tick) begin
          // A basket landing on the final tick still belongs to this round.
          if (time_left_q == 8'd1) begin
            time_left_d    = 8'd0;
            result_score_d = score_next;
            result_valid_d = 1'b1;
            playing_d      = 1'b0;
            state_d        = REPORT;
          end else if (time_left_q != 8'd0) begin
            time_left_d = time_left_q - 8'd1;
          end
        end
      end
      REPORT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          game_over_d    = 1'b1;
          state_d        = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      time_left_q    <= ROUND_T;
      score_q        <= 8'd0;
      result_score_q <= 8'd0;
      playing_q      <= 1'b0;
      game_over_q    <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      time_left_q    <= time_left_d;
      score_q        <= score_d;
      result_score_q <= result_score_d;
      playing_q      <= playing_d;
      game_over_q    <= game_over_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign time_left    = time_left_q;
  assign score        = score_q;
  assign playing      = playing_q;
  assign game_over    = game_over_q;
  assign result_valid = result_valid_q;
  assign result_score = result_score_q;
endmodule
